// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod serializer: shifts a 24-bit frame (second-pad slot + 12 buttons) MSB first, then pulses latch.
// Define GAMEPAD_TX_AUTO_EN for free-running frames every FRAME_GAP idle cycles; otherwise frames follow i_frame_req.
module gamepad_pmod_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned FRAME_GAP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_buttons,
    input  logic        i_present,
    input  logic        i_frame_req,
    output logic        o_pmod_latch,
    output logic        o_pmod_clk,
    output logic        o_pmod_data,
    output logic        o_busy,
    output logic        o_frame_done
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("gamepad_pmod_tx: CLK_DIV out of range 1..255");
    end
    if (FRAME_GAP < 1 || FRAME_GAP > 65535) begin : g_bad_gap
        $error("gamepad_pmod_tx: FRAME_GAP out of range 1..65535");
    end

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [4:0]  bit_q, bit_d;
    logic [7:0]  half_q, half_d;
    logic        ph_q, ph_d;
    logic        latch_q, latch_d;
    logic        pclk_q, pclk_d;
    logic        data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [23:0] frame_word;
    logic [4:0]  bit_prev;
    logic        half_end;
    logic        start;

    // Unplugged pad reads as all ones on the pulled-up data line.
    assign frame_word = i_present ? {12'h000, i_buttons} : 24'hFFFFFF;
    assign bit_prev   = bit_q - 5'd1;
    assign half_end   = (half_q == HALF_LAST);

`ifdef GAMEPAD_TX_AUTO_EN
    localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP);
    logic [15:0] gap_q, gap_d;

    assign start = (gap_q == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gap_q <= '0;
        else     gap_q <= gap_d;
    end

    // The frame_done cycle is itself the first idle cycle of the gap.
    always_comb begin
        gap_d = gap_q;
        if (state_q == S_IDLE) begin
            gap_d = start ? 16'd0 : gap_q + 16'd1;
        end else if (state_q == S_LATCH && half_end && ph_q) begin
            gap_d = 16'd1;
        end
    end
`else
    // A request coinciding with frame_done is dropped, not held over.
    assign start = i_frame_req && !done_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            bit_q   <= '0;
            half_q  <= '0;
            ph_q    <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            ph_q    <= ph_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bit_d   = bit_q;
        half_d  = half_q;
        ph_d    = ph_q;
        latch_d = latch_q;
        pclk_d  = pclk_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_d  = frame_word;
                    data_d  = frame_word[23];
                    bit_d   = 5'd23;
                    half_d  = '0;
                    ph_d    = 1'b0;
                    pclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (!half_end) begin
                    half_d = half_q + 8'd1;
                end else begin
                    half_d = '0;
                    if (!ph_q) begin
                        ph_d   = 1'b1;
                        pclk_d = 1'b1;
                    end else begin
                        ph_d   = 1'b0;
                        pclk_d = 1'b0;
                        if (bit_q == 5'd0) begin
                            latch_d = 1'b1;
                            state_d = S_LATCH;
                        end else begin
                            // Next bit goes out together with the falling shift clock.
                            bit_d  = bit_prev;
                            data_d = word_q[bit_prev];
                        end
                    end
                end
            end

            S_LATCH: begin
                // Latch spans two half-periods, tracked by ph so half stays 8 bits.
                if (!half_end) begin
                    half_d = half_q + 8'd1;
                end else begin
                    half_d = '0;
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d    = 1'b0;
                        latch_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign o_pmod_latch = latch_q;
    assign o_pmod_clk   = pclk_q;
    assign o_pmod_data  = data_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed bench for gamepad_pmod_tx with a behavioural shift-register receiver on the Pmod lines.
module tb_gamepad_pmod_tx;

`ifdef GAMEPAD_TX_AUTO_EN
    localparam int DIV = 1;
    localparam int GAP = 10;
`else
    localparam int DIV = 2;
    localparam int GAP = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] i_buttons;
    logic        i_present;
    logic        i_frame_req;
    logic        o_pmod_latch, o_pmod_clk, o_pmod_data, o_busy, o_frame_done;

    gamepad_pmod_tx #(.CLK_DIV(DIV), .FRAME_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .i_buttons(i_buttons), .i_present(i_present),
        .i_frame_req(i_frame_req), .o_pmod_latch(o_pmod_latch), .o_pmod_clk(o_pmod_clk),
        .o_pmod_data(o_pmod_data), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Receiver model: sample on rising shift clock, capture word on rising latch.
    logic [23:0] rx_sr = '0;
    logic [23:0] rx_word = '0;
    int          rx_cnt = 0;
    always @(posedge o_pmod_clk) begin
        rx_sr  <= {rx_sr[22:0], o_pmod_data};
        rx_cnt <= rx_cnt + 1;
    end
    always @(posedge o_pmod_latch) rx_word <= rx_sr;

    // Data must stay put while the shift clock is high.
    logic pclk_prev = 1'b0;
    logic data_prev = 1'b0;
    int   hold_viol = 0;
    always @(negedge clk) begin
        if (pclk_prev === 1'b1 && o_pmod_clk === 1'b1 && o_pmod_data !== data_prev)
            hold_viol <= hold_viol + 1;
        pclk_prev <= o_pmod_clk;
        data_prev <= o_pmod_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [11:0] b, input logic p);
        @(negedge clk);
        i_buttons   = b;
        i_present   = p;
        i_frame_req = 1'b1;
        @(negedge clk);
        i_frame_req = 1'b0;
    endtask

    // Returns at the negedge where o_frame_done is seen; len counts negedges waited.
    task automatic wait_done(output int len, output int lat);
        len = 0;
        lat = 0;
        while (o_frame_done !== 1'b1 && len < 2000) begin
            @(negedge clk);
            len++;
            if (o_pmod_latch === 1'b1) lat++;
        end
        if (o_frame_done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [11:0] btn;
        logic        pres;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int len, lat, c0, busy_seen;

        vecs[0] = '{12'hA5C, 1'b1, 24'h000A5C};
        vecs[1] = '{12'h000, 1'b1, 24'h000000};
        vecs[2] = '{12'hFFF, 1'b1, 24'h000FFF};
        vecs[3] = '{12'hA5C, 1'b0, 24'hFFFFFF};
        vecs[4] = '{12'h080, 1'b1, 24'h000080};   // only "up"
        vecs[5] = '{12'h001, 1'b1, 24'h000001};   // only "r", the last bit out

        i_buttons = '0; i_present = 1'b1; i_frame_req = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_latch", {31'd0, o_pmod_latch}, 32'd0);
        chk("rst_clk",   {31'd0, o_pmod_clk},   32'd0);
        chk("rst_data",  {31'd0, o_pmod_data},  32'd0);
        chk("rst_busy",  {31'd0, o_busy},       32'd0);
        chk("rst_done",  {31'd0, o_frame_done}, 32'd0);

`ifdef GAMEPAD_TX_AUTO_EN
        i_buttons = 12'h3C1;
        rst = 1'b0;
        len = 0;
        while (o_busy !== 1'b1 && len < 200) begin
            @(negedge clk);
            len++;
        end
        chk("auto_first_busy", len, GAP + 1);
        wait_done(len, lat);
        chk("auto_word", rx_word, 24'h0003C1);
        chk("auto_len",  len, 50 * DIV);
        @(negedge clk);
        wait_done(len, lat);
        chk("auto_period", len + 1, 50 * DIV + GAP);
        @(negedge clk);
        wait_done(len, lat);
        chk("auto_period2", len + 1, 50 * DIV + GAP);
`else
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            c0 = rx_cnt;
            start_req(vecs[i].btn, vecs[i].pres);
            chk($sformatf("v%0d_busy_rise", i), {31'd0, o_busy}, 32'd1);
            chk($sformatf("v%0d_first_bit", i), {31'd0, o_pmod_data}, {31'd0, vecs[i].exp[23]});
            wait_done(len, lat);
            chk($sformatf("v%0d_word", i), rx_word, vecs[i].exp);
            chk($sformatf("v%0d_nclk", i), rx_cnt - c0, 32'd24);
            chk($sformatf("v%0d_latch_len", i), lat, 2 * DIV);
            chk($sformatf("v%0d_frame_len", i), len, 50 * DIV);
            chk($sformatf("v%0d_busy_at_done", i), {31'd0, o_busy}, 32'd0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle_hold", i), {30'd0, o_pmod_clk, o_pmod_latch}, 32'd0);
            chk($sformatf("v%0d_data_hold", i), {31'd0, o_pmod_data}, {31'd0, vecs[i].exp[0]});
        end

        // Snapshot and mid-frame request, then a request on the done cycle.
        start_req(12'hA5C, 1'b1);
        repeat (30) @(negedge clk);
        i_buttons = 12'hFFF; i_present = 1'b0; i_frame_req = 1'b1;
        @(negedge clk);
        i_frame_req = 1'b0;
        wait_done(len, lat);
        chk("snap_word", rx_word, 24'h000A5C);
        i_frame_req = 1'b1;
        @(negedge clk);
        i_frame_req = 1'b0;
        chk("done_cycle_req_ignored", {31'd0, o_busy}, 32'd0);
        busy_seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (o_busy === 1'b1) busy_seen++;
        end
        chk("no_queued_frame", busy_seen, 32'd0);

        // Request on the first cycle after done is accepted.
        i_buttons = 12'h123; i_present = 1'b1;
        start_req(12'h123, 1'b1);
        wait_done(len, lat);
        i_frame_req = 1'b0;
        @(negedge clk);
        i_frame_req = 1'b1;
        @(negedge clk);
        i_frame_req = 1'b0;
        chk("first_idle_req_accepted", {31'd0, o_busy}, 32'd1);
        wait_done(len, lat);
        chk("first_idle_word", rx_word, 24'h000123);

        // Asynchronous reset during bit 12 (11 bits already sent).
        repeat (3) @(negedge clk);
        start_req(12'hFFF, 1'b1);
        repeat (11 * 2 * DIV + 1) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {27'd0, o_pmod_latch, o_pmod_clk, o_pmod_data, o_busy, o_frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {31'd0, o_busy}, 32'd0);
        c0 = rx_cnt;
        start_req(12'h801, 1'b1);
        wait_done(len, lat);
        chk("post_rst_word", rx_word, 24'h000801);
        chk("post_rst_nclk", rx_cnt - c0, 32'd24);
        chk("post_rst_len", len, 50 * DIV);
`endif

        chk("data_stable_while_clk_high", hold_viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
